// File: rtl/photodiode_conditioner.sv
// Laser-harp photodiode conditioning: per-beam synchronizer and debounce filter,
// clean beam levels for the photodiode conduit, and a show-ahead FIFO of
// beam-broken / beam-restored events with a valid/ready handshake.
module photodiode_conditioner #(
  parameter int NUM_BEAMS       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BEAMS-1:0] beam_raw,
  output logic [NUM_BEAMS-1:0] beam_level,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [2:0]           event_beam,
  output logic                 event_broken,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [NUM_BEAMS-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_BEAMS-1:0] s;

  // Shift the asynchronous pins through the flop chain; idle level is "light received".
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '1;
      end
    end else begin
      sync_reg[0] <= beam_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-beam debounce
  // ---------------------------------------------------------------------------
  logic [NUM_BEAMS-1:0] accept;  // beam commits its new level on this edge
  logic [NUM_BEAMS-1:0] pdir;    // direction of the last committed change (1 = broken)

  generate
    for (genvar gi = 0; gi < NUM_BEAMS; gi++) begin : g_beam
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             dir_reg;

      assign accept[gi] = (s[gi] != level_reg) && (cnt_reg == CNT_LAST);

      // Count consecutive mismatching cycles; any interruption discards the run.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b1;
          dir_reg   <= 1'b0;
        end else if (s[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (accept[gi]) begin
          level_reg <= s[gi];
          cnt_reg   <= '0;
          dir_reg   <= ~s[gi];
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign beam_level[gi] = level_reg;
      assign pdir[gi]       = dir_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending events and fixed-priority arbiter (lowest index first)
  // ---------------------------------------------------------------------------
  logic [NUM_BEAMS-1:0] pend_reg, pend_next;
  logic                 arb_found;
  logic [2:0]           arb_sel;
  logic                 slot_valid_reg;
  logic [2:0]           slot_beam_reg;
  logic                 slot_broken_reg;

  // Pick the lowest pending beam; a fresh debounce commit re-arms its bit over the grant clear.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int k = NUM_BEAMS - 1; k >= 0; k--) begin
      if (pend_reg[k]) begin
        arb_found = 1'b1;
        arb_sel   = 3'(k);
      end
    end
    pend_next = pend_reg;
    if (arb_found) begin
      pend_next[arb_sel] = 1'b0;
    end
    pend_next = pend_next | accept;
  end

  // Register the granted event into the FIFO write slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg        <= '0;
      slot_valid_reg  <= 1'b0;
      slot_beam_reg   <= '0;
      slot_broken_reg <= 1'b0;
    end else begin
      pend_reg        <= pend_next;
      slot_valid_reg  <= arb_found;
      slot_beam_reg   <= arb_sel;
      slot_broken_reg <= pdir[arb_sel];
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [3:0]    head;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_pop, do_wr, drop;
  logic          overflow_reg;

  assign event_valid = (count_reg != '0);
  assign do_pop      = event_valid && event_ready;
  assign do_wr       = slot_valid_reg && ((count_reg != FIFO_FULL) || do_pop);
  assign drop        = slot_valid_reg && (count_reg == FIFO_FULL) && !do_pop;

  // Storage array: no reset, contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      fifo_mem[wr_ptr_reg] <= {slot_beam_reg, slot_broken_reg};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky drop flag; a drop on the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clear_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign head         = fifo_mem[rd_ptr_reg];
  assign event_beam   = event_valid ? head[3:1] : 3'd0;
  assign event_broken = event_valid & head[0];
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_photodiode_conditioner.sv
// Self-checking bench for photodiode_conditioner: directed scenarios from the
// test plan plus a randomized run, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_photodiode_conditioner;

  localparam int NB    = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] beam_raw = 8'hFF;
  logic       event_ready = 1'b1;
  logic       clear_overflow = 1'b0;
  logic [7:0] beam_level;
  logic       event_valid;
  logic [2:0] event_beam;
  logic       event_broken;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int ev_seen = 0;

  always #5 clk = ~clk;

  photodiode_conditioner #(
    .NUM_BEAMS      (NB),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .beam_raw      (beam_raw),
    .beam_level    (beam_level),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_beam    (event_beam),
    .event_broken  (event_broken),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pipe [$];   // pin history seen by the synchronizer, newest first
  logic [7:0] m_level;
  int         m_run [NB];   // mismatching samples seen since level last agreed
  logic [7:0] m_pend;
  logic [7:0] m_dir;
  bit         m_slot_v;
  int         m_slot_ev;    // beam*2 + broken
  int         m_fifo [$];
  bit         m_ovf;
  bit         model_on = 1'b0;

  task automatic model_reset();
    m_pipe = {};
    for (int k = 0; k < SYNC; k++) m_pipe.push_back(8'hFF);
    m_level = 8'hFF;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_pend = '0;
    m_dir = '0;
    m_slot_v = 1'b0;
    m_slot_ev = 0;
    m_fifo = {};
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s;
    bit pop, was_full, ovf_set;
    if (reset) begin
      model_reset();
      model_on = 1'b1;
      return;
    end
    s = m_pipe[SYNC-1];
    pop = (m_fifo.size() > 0) && event_ready;
    was_full = (m_fifo.size() == DEPTH);
    ovf_set = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (m_slot_v) begin
      if (!was_full || pop) m_fifo.push_back(m_slot_ev);
      else ovf_set = 1'b1;
    end
    m_slot_v = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (m_pend[i]) begin
        m_slot_v = 1'b1;
        m_slot_ev = i * 2 + int'(m_dir[i]);
        m_pend[i] = 1'b0;
        break;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (s[i] == m_level[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = s[i];
          m_run[i] = 0;
          m_pend[i] = 1'b1;
          m_dir[i] = ~s[i];
        end
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    m_pipe.push_front(beam_raw);
    void'(m_pipe.pop_back());
  endtask

  always @(posedge clk) begin
    if (!reset && event_valid && event_ready) ev_seen++;
    model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("level", beam_level, m_level);
      check("valid", event_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
        check("beam", event_beam, m_fifo[0] >> 1);
        check("broken", event_broken, m_fifo[0] & 1);
      end
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int beam, input int broken);
    check({tag, "_valid"}, event_valid, 1);
    check({tag, "_beam"}, event_beam, beam);
    check({tag, "_broken"}, event_broken, broken);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ev0;
    int b;
    step(3);
    reset = 1'b0;
    check("rst_level", beam_level, 8'hFF);
    check("rst_valid", event_valid, 0);
    check("rst_beam", event_beam, 0);
    check("rst_broken", event_broken, 0);
    check("rst_ovf", overflow, 0);
    step(5);

    $display("[TB] scenario single break");
    beam_raw[3] = 1'b0;
    step(17); check("brk_lvl17", beam_level, 8'hFF);
    step(1);  check("brk_lvl18", beam_level, 8'hF7);
    step(1);  check("brk_v19", event_valid, 0);
    step(1);  check_head("brk_ev", 3, 1);
    step(1);  check("brk_v21", event_valid, 0);
    beam_raw[3] = 1'b1;
    step(18); check("rst_lvl18", beam_level, 8'hFF);
    step(2);  check_head("rest_ev", 3, 0);
    step(20);

    $display("[TB] scenario glitch rejection");
    ev0 = ev_seen;
    beam_raw[5] = 1'b0; step(15); beam_raw[5] = 1'b1;
    step(40);
    check("glitch_lvl", beam_level, 8'hFF);
    check("glitch_events", ev_seen - ev0, 0);
    ev0 = ev_seen;
    beam_raw[5] = 1'b0; step(16); beam_raw[5] = 1'b1;
    step(60);
    check("long_events", ev_seen - ev0, 2);

    $display("[TB] scenario simultaneous");
    beam_raw = 8'hAD;
    step(20); check_head("sim0", 1, 1);
    step(1);  check_head("sim1", 4, 1);
    step(1);  check_head("sim2", 6, 1);
    beam_raw = 8'hFF;
    step(40);

    $display("[TB] scenario overflow");
    event_ready = 1'b0;
    beam_raw = 8'hC0;
    step(30);
    check("ovf_set", overflow, 1);
    check_head("ovf0", 0, 1);
    event_ready = 1'b1;
    step(1); check_head("ovf1", 1, 1);
    step(1); check_head("ovf2", 2, 1);
    step(1); check_head("ovf3", 3, 1);
    step(1); check("ovf_empty", event_valid, 0);
    check("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step(1); clear_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    beam_raw = 8'hFF;
    step(40);

    $display("[TB] scenario full with pop");
    event_ready = 1'b0;
    beam_raw = 8'hF0;
    step(30);
    check("full_ovf", overflow, 0);
    beam_raw = 8'hE0;
    step(19);
    event_ready = 1'b1;
    step(1); check("fp_ovf", overflow, 0); check_head("fp1", 1, 1);
    step(1); check_head("fp2", 2, 1);
    step(1); check_head("fp3", 3, 1);
    step(1); check_head("fp4", 4, 1);
    step(1); check("fp_empty", event_valid, 0);
    beam_raw = 8'hFF;
    step(40);

    $display("[TB] scenario reset mid-operation");
    event_ready = 1'b0;
    beam_raw = 8'hFC;
    step(30);
    check("pre_rst_valid", event_valid, 1);
    beam_raw = 8'hF8;
    step(12);
    reset = 1'b1;
    step(1);
    check("mid_rst_lvl", beam_level, 8'hFF);
    check("mid_rst_valid", event_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    reset = 1'b0;
    event_ready = 1'b1;
    step(17); check("post_rst_lvl17", beam_level, 8'hFF);
    step(1);  check("post_rst_lvl18", beam_level, 8'hF8);
    step(2);  check_head("post_rst_ev", 0, 1);
    beam_raw = 8'hFF;
    step(40);

    $display("[TB] scenario randomized");
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        b = $urandom_range(0, 7);
        beam_raw[b] = ~beam_raw[b];
      end
      if ((c / 250) % 2 == 0) event_ready = ($urandom_range(0, 3) != 0);
      else event_ready = ($urandom_range(0, 7) == 0);
      clear_overflow = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 799) == 0);
      step(1);
    end
    reset = 1'b0;
    clear_overflow = 1'b0;
    event_ready = 1'b1;
    step(60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
